// File: rtl/palette_lut_pkg.sv
// Shared types and helpers for the palette lookup table: state encoding,
// parameter legality checks and the byte-lane merge used for writes and forwarding.
package palette_lut_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  function automatic bit rd_lat_ok(int lat);
    return (lat == 1) || (lat == 2);
  endfunction

  function automatic bit data_w_ok(int w);
    return (w > 0) && ((w % 8) == 0);
  endfunction

  function automatic bit num_rd_ok(int n);
    return (n >= 1) && (n <= 4);
  endfunction

  // One byte lane of a write merge: the enabled lane takes new data, others keep old.
  function automatic logic [7:0] merge_byte(logic [7:0] old_b, logic [7:0] new_b, logic en);
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/palette_lut_if.sv
// Host write handshake and compositor read-port bundle of the palette lookup table.
interface palette_lut_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int NUM_RD = 2
);
  logic                     wr_valid_i;
  logic                     wr_ready_o;
  logic [ADDR_W-1:0]        wr_addr_i;
  logic [DATA_W/8-1:0]      wr_ben_i;
  logic [DATA_W-1:0]        wr_data_i;
  logic [NUM_RD-1:0]        rd_en_i;
  logic [NUM_RD*ADDR_W-1:0] rd_addr_i;
  logic [NUM_RD*DATA_W-1:0] rd_data_o;
  logic [NUM_RD-1:0]        rd_valid_o;

  modport master (
    output wr_valid_i, wr_addr_i, wr_ben_i, wr_data_i, rd_en_i, rd_addr_i,
    input  wr_ready_o, rd_data_o, rd_valid_o
  );

  modport slave (
    input  wr_valid_i, wr_addr_i, wr_ben_i, wr_data_i, rd_en_i, rd_addr_i,
    output wr_ready_o, rd_data_o, rd_valid_o
  );
endinterface

// File: rtl/palette_lut_init_seq.sv
// Init sequencer: walks every address once after reset or clr_i, and reports busy
// until the last entry has been written.
module palette_lut_init_seq
  import palette_lut_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  output logic              busy_o,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr
);

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy_o    = 1'b0;
    init_we   = 1'b0;
    init_addr = cnt;
    case (state)
      ST_INIT: begin
        busy_o  = 1'b1;
        init_we = 1'b1;
        // A clear mid-walk restarts the sweep so every entry is rewritten.
        if (clr_i) begin
          cnt_nxt = '0;
        end else if (cnt == '1) begin
          state_nxt = ST_READY;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + ADDR_W'(1);
        end
      end
      ST_READY: begin
        if (clr_i) begin
          state_nxt = ST_INIT;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_INIT;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/palette_lut.sv
// Multi-read-port colour lookup table with byte-enabled host writes and a built-in
// clear sequencer. Define PALETTE_LUT_BYPASS_EN for same-cycle write-to-read forwarding.
module palette_lut
  import palette_lut_pkg::*;
#(
  parameter int              DATA_W   = 16,
  parameter int              ADDR_W   = 8,
  parameter int              NUM_RD   = 2,
  parameter int              RD_LAT   = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  output logic         busy_o,
  palette_lut_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
    $error("palette_lut: RD_LAT must be 1 or 2");
  end
  if (!data_w_ok(DATA_W)) begin : g_bad_data_w
    $error("palette_lut: DATA_W must be a positive multiple of 8");
  end
  if (!num_rd_ok(NUM_RD)) begin : g_bad_num_rd
    $error("palette_lut: NUM_RD must be 1..4");
  end

  logic              init_we;
  logic [ADDR_W-1:0] init_addr;

  palette_lut_init_seq #(.ADDR_W(ADDR_W)) u_init_seq (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (clr_i),
    .busy_o    (busy_o),
    .init_we   (init_we),
    .init_addr (init_addr)
  );

  // Host writes are only accepted outside the clear sweep and never in a clr_i cycle.
  logic wr_fire;
  assign bus.wr_ready_o = !busy_o && !clr_i;
  assign wr_fire        = bus.wr_valid_i && bus.wr_ready_o;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [NB-1:0]     mem_wben;

  always_comb begin
    mem_we    = init_we || wr_fire;
    mem_waddr = init_we ? init_addr : bus.wr_addr_i;
    mem_wdata = init_we ? INIT_VAL  : bus.wr_data_i;
    mem_wben  = init_we ? {NB{1'b1}} : bus.wr_ben_i;
  end

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_wben[b]) mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rd_raw;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] data_p1;
    logic              vld_p1;

    assign raddr  = bus.rd_addr_i[p*ADDR_W +: ADDR_W];
    // Entries not yet swept still hold stale data, so reads during the sweep are forced.
    assign rd_raw = busy_o ? INIT_VAL : mem[raddr];

`ifdef PALETTE_LUT_BYPASS_EN
    logic hit;
    assign hit = wr_fire && (bus.wr_addr_i == raddr);

    always_comb begin
      rd_word = rd_raw;
      for (int b = 0; b < NB; b++) begin
        rd_word[8*b +: 8] = merge_byte(rd_raw[8*b +: 8], bus.wr_data_i[8*b +: 8],
                                       hit && bus.wr_ben_i[b]);
      end
    end
`else
    assign rd_word = rd_raw;
`endif

    // Stage p1: array read register
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_p1  <= 1'b0;
        data_p1 <= '0;
      end else begin
        vld_p1 <= bus.rd_en_i[p];
        if (bus.rd_en_i[p]) data_p1 <= rd_word;
      end
    end

    if (RD_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] data_p2;
      logic              vld_p2;

      // Stage p2: optional output register
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          vld_p2  <= 1'b0;
          data_p2 <= '0;
        end else begin
          vld_p2 <= vld_p1;
          if (vld_p1) data_p2 <= data_p1;
        end
      end

      assign bus.rd_data_o[p*DATA_W +: DATA_W] = data_p2;
      assign bus.rd_valid_o[p]                 = vld_p2;
    end else begin : g_lat1
      assign bus.rd_data_o[p*DATA_W +: DATA_W] = data_p1;
      assign bus.rd_valid_o[p]                 = vld_p1;
    end
  end

endmodule

// File: tb/tb_palette_lut.sv
// Directed bench for palette_lut: vector table for writes/reads plus hand sequences
// for reset, clear stall, forwarding and reset during the sweep.
module tb_palette_lut;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int NUM_RD = 2;
  localparam int RD_LAT = 1;

`ifdef PALETTE_LUT_BYPASS_EN
  localparam logic [15:0] EXP_SAME_CYCLE = 16'h12FF;
`else
  localparam logic [15:0] EXP_SAME_CYCLE = 16'h00FF;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  palette_lut_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();

  palette_lut #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .RD_LAT   (RD_LAT),
    .INIT_VAL (16'h0000)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (clr),
    .busy_o (busy),
    .bus    (bus)
  );

  typedef struct {
    bit          is_wr;
    int          port;
    logic [7:0]  addr;
    logic [1:0]  ben;
    logic [15:0] data;
  } vec_t;

  vec_t vecs[12];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [15:0] data, input logic [1:0] ben);
    int n = 0;
    bus.wr_valid_i = 1'b1;
    bus.wr_addr_i  = addr;
    bus.wr_data_i  = data;
    bus.wr_ben_i   = ben;
    #1;
    while (!bus.wr_ready_o && n < 1000) begin
      tick();
      n++;
    end
    chk("wr_accept", {31'b0, bus.wr_ready_o}, 32'd1);
    tick();
    bus.wr_valid_i = 1'b0;
  endtask

  task automatic do_read(input int p, input logic [7:0] addr, input logic [15:0] exp,
                         input string nm);
    bus.rd_en_i[p] = 1'b1;
    bus.rd_addr_i[p*ADDR_W +: ADDR_W] = addr;
    tick();
    bus.rd_en_i = '0;
    repeat (RD_LAT - 1) tick();
    chk({nm, "_data"}, 32'(bus.rd_data_o[p*DATA_W +: DATA_W]), 32'(exp));
    chk({nm, "_valid"}, 32'(bus.rd_valid_o), 32'(1 << p));
    tick();
    chk({nm, "_pulse"}, 32'(bus.rd_valid_o), 32'd0);
  endtask

  task automatic measure_busy(input string nm);
    int  n = 0;
    bit  rdy_seen = 0;
    while (busy && n < 1000) begin
      if (bus.wr_ready_o) rdy_seen = 1;
      n++;
      tick();
    end
    chk({nm, "_cycles"}, 32'(n), 32'd256);
    chk({nm, "_ready_low"}, {31'b0, rdy_seen}, 32'd0);
  endtask

  initial begin
    int errs;
    int n;
    bit rdy_seen;

    bus.wr_valid_i = 1'b0;
    bus.wr_addr_i  = '0;
    bus.wr_data_i  = '0;
    bus.wr_ben_i   = '0;
    bus.rd_en_i    = '0;
    bus.rd_addr_i  = '0;

    vecs[0]  = '{1, 0, 8'h12, 2'b11, 16'hABCD};
    vecs[1]  = '{1, 0, 8'h12, 2'b01, 16'h00EF};
    vecs[2]  = '{0, 0, 8'h12, 2'b00, 16'hABEF};
    vecs[3]  = '{1, 0, 8'h05, 2'b11, 16'h5555};
    vecs[4]  = '{1, 0, 8'hFF, 2'b11, 16'h0FF0};
    vecs[5]  = '{1, 0, 8'h40, 2'b11, 16'h00FF};
    vecs[6]  = '{1, 0, 8'h80, 2'b10, 16'hA5A5};
    vecs[7]  = '{0, 1, 8'h80, 2'b00, 16'hA500};
    vecs[8]  = '{1, 0, 8'h81, 2'b00, 16'hFFFF};
    vecs[9]  = '{0, 0, 8'h81, 2'b00, 16'h0000};
    vecs[10] = '{0, 1, 8'h12, 2'b00, 16'hABEF};
    vecs[11] = '{0, 0, 8'hFF, 2'b00, 16'h0FF0};

    // Reset state
    #12;
    chk("rst_busy", {31'b0, busy}, 32'd1);
    chk("rst_ready", {31'b0, bus.wr_ready_o}, 32'd0);
    chk("rst_valid", 32'(bus.rd_valid_o), 32'd0);
    chk("rst_data", 32'(bus.rd_data_o), 32'd0);

    // Release and time the sweep
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    measure_busy("init");

    errs = 0;
    for (int a = 0; a < 256; a++) begin
      bus.rd_en_i = 2'b11;
      bus.rd_addr_i = {8'(255 - a), 8'(a)};
      tick();
      bus.rd_en_i = '0;
      repeat (RD_LAT - 1) tick();
      if (bus.rd_data_o !== 32'd0 || bus.rd_valid_o !== 2'b11) errs++;
    end
    chk("init_all_zero", 32'(errs), 32'd0);

    // Vector table
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].ben);
      else do_read(vecs[i].port, vecs[i].addr, vecs[i].data, $sformatf("vec%0d", i));
    end

    // Both ports in one cycle, then an idle port holds
    bus.rd_en_i = 2'b11;
    bus.rd_addr_i = {8'hFF, 8'h05};
    tick();
    bus.rd_en_i = '0;
    repeat (RD_LAT - 1) tick();
    chk("dual_p0", 32'(bus.rd_data_o[15:0]), 32'h5555);
    chk("dual_p1", 32'(bus.rd_data_o[31:16]), 32'h0FF0);
    chk("dual_valid", 32'(bus.rd_valid_o), 32'd3);
    tick();
    do_read(0, 8'h12, 16'hABEF, "solo_p0");
    chk("idle_p1_hold", 32'(bus.rd_data_o[31:16]), 32'h0FF0);
    chk("idle_p1_valid", {31'b0, bus.rd_valid_o[1]}, 32'd0);

    // Same-cycle write and read of one address
    bus.wr_valid_i = 1'b1;
    bus.wr_addr_i  = 8'h40;
    bus.wr_data_i  = 16'h1234;
    bus.wr_ben_i   = 2'b10;
    bus.rd_en_i[0] = 1'b1;
    bus.rd_addr_i[7:0] = 8'h40;
    #1;
    chk("same_ready", {31'b0, bus.wr_ready_o}, 32'd1);
    tick();
    bus.wr_valid_i = 1'b0;
    bus.rd_en_i = '0;
    repeat (RD_LAT - 1) tick();
    chk("same_cycle_rd", 32'(bus.rd_data_o[15:0]), 32'(EXP_SAME_CYCLE));
    tick();
    do_read(0, 8'h40, 16'h12FF, "after_merge");

    // Clear while a write is pending
    bus.wr_valid_i = 1'b1;
    bus.wr_addr_i  = 8'h33;
    bus.wr_data_i  = 16'hBEEF;
    bus.wr_ben_i   = 2'b11;
    clr = 1'b1;
    #1;
    chk("clr_stall", {31'b0, bus.wr_ready_o}, 32'd0);
    tick();
    clr = 1'b0;
    n = 0;
    rdy_seen = 0;
    while (busy && n < 1000) begin
      if (bus.wr_ready_o) rdy_seen = 1;
      if (n == 3) begin
        bus.rd_en_i[1] = 1'b1;
        bus.rd_addr_i[15:8] = 8'h12;
      end
      if (n == 4) bus.rd_en_i = '0;
      if (n == 10) chk("busy_read_init", 32'(bus.rd_data_o[31:16]), 32'd0);
      n++;
      tick();
    end
    chk("clr_cycles", 32'(n), 32'd256);
    chk("clr_ready_low", {31'b0, rdy_seen}, 32'd0);
    chk("stalled_ready", {31'b0, bus.wr_ready_o}, 32'd1);
    tick();
    bus.wr_valid_i = 1'b0;
    do_read(0, 8'h33, 16'hBEEF, "stalled_wr");
    do_read(1, 8'h12, 16'h0000, "clr_12");
    do_read(0, 8'h40, 16'h0000, "clr_40");
    do_read(1, 8'hFF, 16'h0000, "clr_ff");

    // Reset during the sweep with a read in flight
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (99) tick();
    bus.rd_en_i[0] = 1'b1;
    bus.rd_addr_i[7:0] = 8'h00;
    tick();
    bus.rd_en_i = '0;
    chk("mid_init_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'b0, busy}, 32'd1);
    chk("mid_rst_ready", {31'b0, bus.wr_ready_o}, 32'd0);
    chk("mid_rst_valid", 32'(bus.rd_valid_o), 32'd0);
    chk("mid_rst_data", 32'(bus.rd_data_o), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    measure_busy("rst_again");
    do_read(1, 8'h33, 16'h0000, "post_rst_33");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
